sram_stream_reader: RTL and testbench
=====================================

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the SRAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the word width.
REQ-003 Parameter DEPTH, default 256, SHALL set the SRAM word count, a power of two equal to 2^ADDR_WIDTH.
REQ-004 i_clk  in  1  SHALL be the single clock; the SRAM read port is clocked by the same clock.
REQ-005 i_resetN  in  1  SHALL be the synchronous, active-low reset.
REQ-006 i_start  in  1  SHALL be a one-cycle burst request.
REQ-007 i_baseAddr  in  ADDR_WIDTH  SHALL be the first word address, sampled with i_start.
REQ-008 i_length  in  ADDR_WIDTH+1  SHALL be the word count, sampled with i_start.
REQ-009 o_readAddr  out  ADDR_WIDTH  SHALL be the registered address driven to the SRAM read port.
REQ-010 i_readData  in  DATA_WIDTH  SHALL be the SRAM read data, valid one cycle after its address.
REQ-011 o_data  out  DATA_WIDTH  SHALL be the stream word.
REQ-012 o_valid  out  1  SHALL flag o_data valid.
REQ-013 i_ready  in  1  SHALL flag sink acceptance.
REQ-014 o_busy  out  1  SHALL be high from the edge accepting i_start until the edge after the final word transfer.
REQ-015 o_done  out  1  SHALL pulse for one cycle after the final word transfer.

Function
REQ-016 FSM states SHALL be IDLE, RUN (issuing reads), DRAIN (all reads issued, words pending); IDLE->RUN on i_start with i_length!=0; RUN->DRAIN when the issued count reaches the length; DRAIN->IDLE on the final transfer.
REQ-017 i_start with i_length==0 SHALL issue no reads and pulse o_done in the following cycle.
REQ-018 i_start while o_busy is high SHALL be ignored.
REQ-019 At the start edge o_readAddr SHALL load i_baseAddr; each later issue SHALL increment it modulo DEPTH (DEPTH-1 wraps to 0).
REQ-020 A transfer SHALL occur on each edge with o_valid && i_ready high; o_data SHALL hold stable while o_valid && !i_ready.
REQ-021 Read data SHALL be captured into a 4-entry FIFO on the edge after it appears on i_readData, tracked by a 2-stage issue-valid shift register.
REQ-022 Outstanding count (issued, not yet transferred) SHALL never exceed 4; issues SHALL stall at 4, so no word is ever lost under backpressure.
REQ-023 No combinational path SHALL exist from i_ready to o_readAddr.
REQ-024 First o_valid SHALL assert 2 edges after the start edge; with i_ready held high, throughput SHALL be 1 word per cycle with no bubbles.
REQ-025 i_length values above DEPTH SHALL wrap and re-read addresses in order.
REQ-026 o_done SHALL coincide with o_busy falling; a new i_start SHALL be accepted in the same cycle o_done is high.

Reset
REQ-027 While i_resetN is low at an edge: state IDLE, o_readAddr 0, o_valid 0, o_busy 0, o_done 0, FIFO empty, outstanding 0, shift register cleared.
REQ-028 Reset mid-burst SHALL discard all in-flight and buffered words; no o_valid SHALL follow until a new i_start.

Structure
REQ-029 Shared package sram_stream_pkg SHALL hold the FSM state enum and the FIFO depth constant (4).
REQ-030 The FIFO SHALL be a sub-module sram_read_fifo (synchronous, 4 entries, full/empty flags).

Verification
REQ-031 base 0x10, length 4, i_ready high -> o_data = mem[0x10..0x13] on 4 consecutive cycles, first o_valid 2 edges after start, o_done once.
REQ-032 base 0xFE, length 4 -> o_readAddr FE,FF,00,01; data in that order.
REQ-033 length 8, i_ready low 10 cycles then high -> outstanding peaks at 4, o_data stable, all 8 words delivered in order.
REQ-034 length 0 -> no address change, no o_valid, o_done one cycle after start.
REQ-035 i_resetN low at word 3 of 8 -> outputs at reset values next cycle, no further o_valid; new burst runs cleanly.
REQ-036 i_start during busy -> ignored; i_start on o_done cycle -> new burst starts.

Source files
------------

// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM stream reader and its read-data FIFO.
package sram_stream_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Burst-request, SRAM read-port and stream-output signals of the reader.
// Stream handshake: a word moves on every clock edge where o_valid and i_ready
// are both high; while o_valid is high and i_ready low, o_data holds its value.
interface sram_stream_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_baseAddr;
    logic [ADDR_WIDTH:0]   i_length;
    logic [ADDR_WIDTH-1:0] o_readAddr;
    logic [DATA_WIDTH-1:0] i_readData;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_baseAddr, i_length, i_readData, i_ready,
        output o_readAddr, o_data, o_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_baseAddr, i_length, i_readData, i_ready,
        input  o_readAddr, o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/sram_read_fifo.sv
// Four-entry synchronous FIFO buffering SRAM read data ahead of the stream sink.
module sram_read_fifo
    import sram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_CNT_W-1:0] count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_stream_reader.sv
// Reads a burst of consecutive SRAM words and streams them out over valid/ready,
// keeping at most FIFO_DEPTH words outstanding so backpressure never drops data.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_resetN,
    sram_stream_reader_if.master  bus,
    output state_t                dbg_state,
    output logic [FIFO_CNT_W-1:0] dbg_outstanding
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [FIFO_CNT_W-1:0] OUT_MAX  = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_next;
    logic                  issue;
    logic                  done_next;
    logic                  done_q;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_cnt;
    logic [1:0]            issue_sr;
    logic [FIFO_CNT_W-1:0] outstanding;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign xfer      = !fifo_empty && bus.i_ready;
    assign addr_next = (read_addr == ADDR_MAX) ? '0 : read_addr + ADDR_WIDTH'(1);

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue gating uses only registered counts, so i_ready never reaches o_readAddr.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_length != '0) begin
                        issue      = 1'b1;
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issued_cnt != len_q && outstanding < OUT_MAX && !fifo_full) begin
                    issue = 1'b1;
                end
                if (issued_cnt == len_q || (issue && issued_cnt + LEN_ONE == len_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && outstanding == FIFO_CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            read_addr   <= '0;
            len_q       <= '0;
            issued_cnt  <= '0;
            issue_sr    <= '0;
            outstanding <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= done_next;
            issue_sr <= {issue_sr[0], issue};
            if (issue) begin
                if (state == IDLE) begin
                    read_addr  <= bus.i_baseAddr;
                    len_q      <= bus.i_length;
                    issued_cnt <= LEN_ONE;
                end else begin
                    read_addr  <= addr_next;
                    issued_cnt <= issued_cnt + LEN_ONE;
                end
            end
            case ({issue, xfer})
                2'b10:   outstanding <= outstanding + FIFO_CNT_W'(1);
                2'b01:   outstanding <= outstanding - FIFO_CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // issue_sr[1] marks the cycle in which the SRAM is presenting that word.
    sram_read_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_resetN),
        .push  (issue_sr[1]),
        .wdata (bus.i_readData),
        .pop   (xfer),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.o_readAddr  = read_addr;
    assign bus.o_data      = fifo_rdata;
    assign bus.o_valid     = !fifo_empty;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = done_q;
    assign dbg_state       = state;
    assign dbg_outstanding = outstanding;
endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, randomized bursts and backpressure,
// checked against an expected-word queue built from the burst parameters.
module tb_sram_stream_reader;
    import sram_stream_pkg::*;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    state_t     dbg_state;
    logic [2:0] dbg_outstanding;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int         vectors = 0;
    int         miscompares = 0;

    sram_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    sram_stream_reader #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .DEPTH(256)
    ) dut (
        .i_clk           (clk),
        .i_resetN        (resetN),
        .bus             (bus),
        .dbg_state       (dbg_state),
        .dbg_outstanding (dbg_outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.i_readData <= mem[bus.o_readAddr];
    end

    task automatic test_reset();
        resetN = 1'b0;
        bus.i_start = 1'b0;
        bus.i_baseAddr = '0;
        bus.i_length = '0;
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b, required 0 0 0", bus.o_valid, bus.o_busy, bus.o_done);
        end
        vectors++;
        if (bus.o_readAddr !== 8'h00 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_addr_state: addr=%h state=%0d, required 00 IDLE", bus.o_readAddr, dbg_state);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the o_done cycle.
    task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                             input int inject_cyc, input string name);
        int         first_valid;
        int         done_cyc;
        int         peak;
        int         budget;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] addr_before;
        logic [7:0] exp_w;
        addr_before = bus.o_readAddr;
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[8'(int'(base) + i)]);
        bus.i_start = 1'b1;
        bus.i_baseAddr = base;
        bus.i_length = len;
        @(negedge clk);
        bus.i_start = 1'b0;
        budget = int'(len) * 20 + 40;
        first_valid = -1;
        done_cyc = -1;
        peak = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < budget; c++) begin
            bus.i_start = (c == inject_cyc);
            if (c == inject_cyc) begin
                bus.i_baseAddr = 8'($urandom);
                bus.i_length = 9'($urandom_range(1, 9));
            end
            case (mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_ready = (c >= 10);
            endcase
            if (c == 0 && len != 0) begin
                vectors++;
                if (bus.o_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_rise: busy=%b, required 1", name, bus.o_busy);
                end
            end
            if (mode == 0 && c < int'(len)) begin
                vectors++;
                if (bus.o_readAddr !== 8'(int'(base) + c)) begin
                    miscompares++;
                    $display("FAIL %s issue_addr c=%0d: addr=%h, required %h", name, c, bus.o_readAddr, 8'(int'(base) + c));
                end
            end
            if (mode == 2 && c == 9) begin
                vectors++;
                if (bus.o_readAddr !== 8'(int'(base) + 3)) begin
                    miscompares++;
                    $display("FAIL %s stall_addr: addr=%h, required %h", name, bus.o_readAddr, 8'(int'(base) + 3));
                end
            end
            if (prev_stall) begin
                vectors++;
                if (bus.o_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL %s hold_data c=%0d: data=%h, required %h", name, c, bus.o_data, prev_data);
                end
            end
            if (bus.o_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_word c=%0d: data=%h, required no word", name, c, bus.o_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.o_data !== exp_w) begin
                        miscompares++;
                        $display("FAIL %s word c=%0d: data=%h, required %h", name, c, bus.o_data, exp_w);
                    end
                end
            end
            prev_stall = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
            prev_data = bus.o_data;
            if (int'(dbg_outstanding) > peak) peak = int'(dbg_outstanding);
            if (bus.o_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL %s done_timeout: no o_done within %0d cycles, required a pulse", name, budget);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s words_missing: %0d left, required 0", name, exp_q.size());
        end
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_fall: busy=%b on done cycle, required 0", name, bus.o_busy);
        end
        vectors++;
        if (peak > 4) begin
            miscompares++;
            $display("FAIL %s outstanding_max: peak=%0d, required <=4", name, peak);
        end
        if (len != 0) begin
            vectors++;
            if (first_valid != 2) begin
                miscompares++;
                $display("FAIL %s first_valid: cycle=%0d, required 2", name, first_valid);
            end
        end else begin
            vectors++;
            if (first_valid != -1 || bus.o_readAddr !== addr_before) begin
                miscompares++;
                $display("FAIL %s zero_len: first_valid=%0d addr=%h, required -1 %h", name, first_valid, bus.o_readAddr, addr_before);
            end
        end
        if (mode == 0) begin
            vectors++;
            if (done_cyc != ((len == 0) ? 0 : int'(len) + 2)) begin
                miscompares++;
                $display("FAIL %s done_cycle: cycle=%0d, required %0d", name, done_cyc, (len == 0) ? 0 : int'(len) + 2);
            end
        end
        if (mode == 2 && len >= 4) begin
            vectors++;
            if (peak != 4) begin
                miscompares++;
                $display("FAIL %s outstanding_peak: peak=%0d, required 4", name, peak);
            end
        end
    endtask

    task automatic test_idle(input int n, input string name);
        bus.i_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s idle c=%0d: valid=%b done=%b, required 0 0", name, c, bus.o_valid, bus.o_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int         xfers;
        logic [7:0] exp_w;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(mem[8'(8'h40 + i)]);
        bus.i_start = 1'b1;
        bus.i_baseAddr = 8'h40;
        bus.i_length = 9'd8;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        xfers = 0;
        for (int c = 0; c < 40 && xfers < 2; c++) begin
            if (bus.o_valid === 1'b1) begin
                exp_w = exp_q.pop_front();
                vectors++;
                if (bus.o_data !== exp_w) begin
                    miscompares++;
                    $display("FAIL reset_mid word: data=%h, required %h", bus.o_data, exp_w);
                end
                xfers++;
            end
            @(negedge clk);
        end
        vectors++;
        if (xfers != 2) begin
            miscompares++;
            $display("FAIL reset_mid timeout: %0d words seen, required 2", xfers);
        end
        resetN = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_readAddr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid outputs: valid=%b busy=%b done=%b addr=%h, required 0 0 0 00", bus.o_valid, bus.o_busy, bus.o_done, bus.o_readAddr);
        end
        resetN = 1'b1;
        exp_q.delete();
        test_idle(8, "reset_mid");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        bus.i_readData = '0;
        test_reset();
        run_burst(8'h10, 9'd4, 0, -1, "basic");
        test_idle(3, "basic");
        run_burst(8'hFE, 9'd4, 0, -1, "wrap");
        test_idle(2, "wrap");
        run_burst(8'h60, 9'd8, 2, -1, "backpressure");
        test_idle(2, "backpressure");
        run_burst(8'h55, 9'd0, 0, -1, "zero_len");
        test_idle(2, "zero_len");
        test_reset_mid();
        run_burst(8'h70, 9'd8, 0, -1, "after_reset");
        run_burst(8'h80, 9'd6, 0, 3, "busy_ignore");
        test_idle(3, "busy_ignore");
        run_burst(8'h20, 9'd3, 0, -1, "b2b_first");
        run_burst(8'h30, 9'd5, 0, -1, "b2b_second");
        test_idle(2, "b2b");
        run_burst(8'hF0, 9'd300, 0, -1, "long_wrap");
        for (int k = 0; k < 8; k++) begin
            run_burst(8'($urandom), 9'($urandom_range(1, 24)), 1, -1, "random");
        end
        test_idle(3, "final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
